serial_rx_controller: RTL

Sequences the receive side of the inter-board serial link. Uses an oversampling counter to detect and confirm the start bit, sample each data bit at mid-bit, check the stop bit, and assemble a parallel word. Delivers each word to game logic through a registered valid/ready handshake, with framing-error and overrun reporting. Sits between the raw serial input pin, already synchronized to clk, and the game move decoder.

---
 rtl/serial_rx_controller_if.sv | 43 ++++
 rtl/serial_rx_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_controller_if.sv
// -----------------------------------------------------------------------------
// serial_rx_controller_if
// Word-delivery bundle between the serial receive controller and the game
// move decoder.
//   rx_data   : received word, LSB received first        (controller -> consumer)
//   rx_valid  : rx_data holds an unconsumed word          (controller -> consumer)
//   rx_ready  : consumer accepts rx_data this cycle        (consumer -> controller)
//   frame_err : one-cycle pulse, stop bit was invalid      (controller -> consumer)
//   overrun   : sticky, a good frame was dropped           (controller -> consumer)
//   clr_err   : clears the sticky overrun flag             (consumer -> controller)
//   busy      : receiver is inside a frame                 (controller -> consumer)
// -----------------------------------------------------------------------------
interface serial_rx_controller_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              frame_err;
   logic              overrun;
   logic              clr_err;
   logic              busy;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      output busy,
      input  rx_ready,
      input  clr_err
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      input  busy,
      output rx_ready,
      output clr_err
   );
endinterface

// File: rtl/serial_rx_controller.sv
// -----------------------------------------------------------------------------
// serial_rx_controller
// Receive sequencer for the inter-board serial link. An oversample counter
// confirms the start bit at mid-bit, samples every data bit at mid-bit,
// checks the stop bit and assembles a parallel word, which is handed to the
// game move decoder over a registered valid/ready handshake.
// Line format: idle 0, start bit 1, DATA_W data bits LSB first, stop bit 0.
// Ports:
//   clk         : major clock
//   rst         : synchronous, active-low reset
//   sample_tick : oversample enable, bit timing advances only on ticks
//   rx          : serial line, already synchronized to clk
//   bus         : word delivery / status bundle (master side)
// -----------------------------------------------------------------------------
module serial_rx_controller #(
   parameter int OS     = 16,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_tick,
   input  logic                   rx,
   serial_rx_controller_if.master bus
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OS / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t            state_r, state_next_s;
   logic [CNT_W-1:0]  cnt_r, cnt_next_s;
   logic [IDX_W-1:0]  idx_r, idx_next_s;
   logic [DATA_W-1:0] shift_r, shift_next_s;
   logic              good_set_s, bad_set_s;

   // Stop-sample outcome, held one cycle so delivery/error land on the next edge
   logic              good_pend_r, bad_pend_r;

   logic [DATA_W-1:0] rx_data_r;
   logic              rx_valid_r, frame_err_r, overrun_r, busy_r;
   logic              load_s, ovr_set_s;
   logic              rx_valid_next_s, overrun_next_s;

   // Bit-timing FSM register and receive datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         idx_r       <= IDX_ZERO;
         shift_r     <= {DATA_W{1'b0}};
         good_pend_r <= 1'b0;
         bad_pend_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         cnt_r       <= cnt_next_s;
         idx_r       <= idx_next_s;
         shift_r     <= shift_next_s;
         good_pend_r <= good_set_s;
         bad_pend_r  <= bad_set_s;
         busy_r      <= (state_next_s != IDLE);
      end
   end

   // Next-state and datapath updates; nothing moves between sample ticks
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      idx_next_s   = idx_r;
      shift_next_s = shift_r;
      good_set_s   = 1'b0;
      bad_set_s    = 1'b0;
      if (sample_tick) begin
         case (state_r)
            IDLE: begin
               if (rx) begin
                  state_next_s = START;
                  cnt_next_s   = CNT_ZERO;
               end else begin
                  state_next_s = IDLE;
               end
            end
            START: begin
               if (cnt_r == CNT_HALF) begin
                  cnt_next_s = CNT_ZERO;
                  idx_next_s = IDX_ZERO;
                  // A start bit that is gone by mid-bit was a glitch, not an error
                  if (rx) begin
                     state_next_s = DATA;
                  end else begin
                     state_next_s = IDLE;
                  end
               end else begin
                  cnt_next_s = cnt_r + CNT_ONE;
               end
            end
            DATA: begin
               if (cnt_r == CNT_LAST) begin
                  shift_next_s[idx_r] = rx;
                  cnt_next_s          = CNT_ZERO;
                  if (idx_r == IDX_LAST) begin
                     state_next_s = STOP;
                     idx_next_s   = IDX_ZERO;
                  end else begin
                     idx_next_s = idx_r + IDX_ONE;
                  end
               end else begin
                  cnt_next_s = cnt_r + CNT_ONE;
               end
            end
            STOP: begin
               if (cnt_r == CNT_LAST) begin
                  state_next_s = IDLE;
                  cnt_next_s   = CNT_ZERO;
                  good_set_s   = ~rx;
                  bad_set_s    = rx;
               end else begin
                  cnt_next_s = cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_next_s = IDLE;
               cnt_next_s   = CNT_ZERO;
               idx_next_s   = IDX_ZERO;
            end
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // Delivery decision: a simultaneous consume frees the slot for the new word
   always_comb begin
      load_s          = good_pend_r & (~rx_valid_r | bus.rx_ready);
      ovr_set_s       = good_pend_r & rx_valid_r & ~bus.rx_ready;
      rx_valid_next_s = rx_valid_r;
      overrun_next_s  = overrun_r;
      if (load_s) begin
         rx_valid_next_s = 1'b1;
      end else if (rx_valid_r && bus.rx_ready) begin
         rx_valid_next_s = 1'b0;
      end else begin
         rx_valid_next_s = rx_valid_r;
      end
      // A new overrun wins over a same-cycle clear
      if (ovr_set_s) begin
         overrun_next_s = 1'b1;
      end else if (bus.clr_err) begin
         overrun_next_s = 1'b0;
      end else begin
         overrun_next_s = overrun_r;
      end
   end

   // Handshake and status registers, updated every clk cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_data_r   <= {DATA_W{1'b0}};
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         if (load_s) begin
            rx_data_r <= shift_r;
         end else begin
            rx_data_r <= rx_data_r;
         end
         rx_valid_r  <= rx_valid_next_s;
         frame_err_r <= bad_pend_r;
         overrun_r   <= overrun_next_s;
      end
   end

   assign bus.rx_data   = rx_data_r;
   assign bus.rx_valid  = rx_valid_r;
   assign bus.frame_err = frame_err_r;
   assign bus.overrun   = overrun_r;
   assign bus.busy      = busy_r;

endmodule
